// File: rtl/ad7609_pkg.sv
// Shared constants and types for the AD7609 sample scheduler.
package ad7609_pkg;

    localparam int STATE_W    = 3;
    localparam int CH_NUM     = 8;
    localparam int CH_W       = 16;
    localparam int FRAME_W    = CH_NUM * CH_W;
    localparam int PERIOD_MIN = 200;

    // Scheduler state codes; the numeric values are visible on the State debug port.
    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        REQ       = 3'd2,
        WAIT_DONE = 3'd3,
        DRAIN     = 3'd4
    } sched_state_t;

endpackage

// File: rtl/ad7609_tick_gen.sv
// Sample-period counter: clamps the requested period to PERIOD_MIN and emits a
// one-cycle tick every eff_period cycles while run is high.
module ad7609_tick_gen
    import ad7609_pkg::*;
#(
    parameter int PERIOD_W = 24
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                run,
    input  logic [PERIOD_W-1:0] Period,
    output logic                tick
);

    logic [PERIOD_W-1:0] eff_period;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] count_q;
    logic                armed_q;

    assign eff_period = (Period < PERIOD_W'(PERIOD_MIN)) ? PERIOD_W'(PERIOD_MIN) : Period;

    // The first running cycle only samples the period, so the first tick lands
    // eff_period cycles after that load cycle; afterwards the period is
    // resampled on every wrap.
    assign tick = armed_q && (count_q == period_q - PERIOD_W'(1));

    // Counter state: held clear while stopped, load cycle on start, then count/wrap.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count_q  <= '0;
            period_q <= PERIOD_W'(PERIOD_MIN);
            armed_q  <= 1'b0;
        end else if (!run) begin
            count_q <= '0;
            armed_q <= 1'b0;
        end else if (!armed_q) begin
            period_q <= eff_period;
            armed_q  <= 1'b1;
        end else if (tick) begin
            count_q  <= '0;
            period_q <= eff_period;
        end else begin
            count_q <= count_q + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/ad7609_sample_sched.sv
// AD7609 sample scheduler: periodic reader requests, oversampling pins, frame
// capture with valid/ready output and miss/drop/timeout statistics.
module ad7609_sample_sched
    import ad7609_pkg::*;
#(
    parameter int PERIOD_W    = 24,
    parameter int TIMEOUT_CYC = 100000,
    parameter int CNT_W       = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Enable,
    input  logic [PERIOD_W-1:0] Period,
    input  logic [2:0]          Os_cfg,
    output logic                Os2,
    output logic                Os1,
    output logic                Os0,
    output logic                Rd_req,
    input  logic                Rd_done,
    input  logic [FRAME_W-1:0]  Rd_data,
    output logic                Rd_abort,
    output logic [FRAME_W-1:0]  Data_out,
    output logic                Data_valid,
    input  logic                Data_ready,
    output logic [CNT_W-1:0]    Sample_cnt,
    output logic [CNT_W-1:0]    Miss_cnt,
    output logic [CNT_W-1:0]    Drop_cnt,
    output logic                Timeout,
    output logic [STATE_W-1:0]  State
);

    localparam int              TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    sched_state_t    state_q;
    sched_state_t    state_d;
    logic            tick;
    logic            run;
    logic            frame_end;
    logic [TO_W-1:0] to_cnt_q;
    logic [2:0]      os_q;
    logic            enable_q;
    logic            accept;
    logic            capture;
    logic            load;
    logic            miss;

    assign run = (state_q != IDLE);

    ad7609_tick_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tick_gen (
        .Clk    (Clk),
        .Rst    (Rst),
        .run    (run),
        .Period (Period),
        .tick   (tick)
    );

    // A frame completes into the register if it is empty or being emptied this cycle.
    assign accept  = Data_valid && Data_ready;
    assign capture = (state_q == WAIT_DONE) && Rd_done;
    assign load    = capture && (!Data_valid || accept);
    assign miss    = tick && ((state_q == REQ) || (state_q == WAIT_DONE));

    assign {Os2, Os1, Os0} = os_q;
    assign State           = state_q;

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and strobe outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would infer a latch.
        state_d   = state_q;
        Rd_req    = 1'b0;
        Rd_abort  = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (Enable) state_d = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (!Enable)   state_d = IDLE;
                else if (tick) state_d = REQ;
            end
            REQ: begin
                Rd_req  = 1'b1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (Rd_done) begin
                    frame_end = 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    Rd_abort  = 1'b1;
                    frame_end = 1'b1;
                end
                if (frame_end) state_d = Enable ? WAIT_TICK : DRAIN;
            end
            DRAIN: begin
                if (Enable)          state_d = WAIT_TICK;
                else if (!Data_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Oversampling pins: loaded on start and on entry to REQ, so they never move mid-frame.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            os_q <= 3'b000;
        end else if ((state_q == IDLE && Enable) || state_d == REQ) begin
            os_q <= Os_cfg;
        end
    end

    // Request-to-done watchdog, restarted for every request.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)                         to_cnt_q <= '0;
        else if (state_q == REQ)         to_cnt_q <= '0;
        else if (state_q == WAIT_DONE)   to_cnt_q <= to_cnt_q + TO_W'(1);
    end

    // Sticky timeout flag, cleared when sampling is re-enabled.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            enable_q <= 1'b0;
            Timeout  <= 1'b0;
        end else begin
            enable_q <= Enable;
            if (Rd_abort)                 Timeout <= 1'b1;
            else if (Enable && !enable_q) Timeout <= 1'b0;
        end
    end

    // Output frame register and valid/ready handshake.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            // NOTE: the wide data register is reset because its value is visible
            // on Data_out right after reset; a pure datapath register would not need it.
            Data_out   <= '0;
            Data_valid <= 1'b0;
        end else if (load) begin
            Data_out   <= Rd_data;
            Data_valid <= 1'b1;
        end else if (accept) begin
            Data_valid <= 1'b0;
        end
    end

    // Statistics: captured frames wrap, missed ticks and dropped frames saturate.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Sample_cnt <= '0;
            Miss_cnt   <= '0;
            Drop_cnt   <= '0;
        end else begin
            if (load)                         Sample_cnt <= Sample_cnt + CNT_W'(1);
            if (miss && Miss_cnt != '1)       Miss_cnt   <= Miss_cnt + CNT_W'(1);
            if (capture && !load && Drop_cnt != '1) Drop_cnt <= Drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ad7609_sample_sched.sv
// Self-checking bench for ad7609_sample_sched: reader model, frame scoreboard
// and directed scenarios for timing, clamping, misses, drops, timeout and reset.
module tb_ad7609_sample_sched;
    import ad7609_pkg::*;

    localparam int PERIOD_W    = 24;
    localparam int TIMEOUT_CYC = 1600;
    localparam int CNT_W       = 16;

    logic                Clk;
    logic                Rst;
    logic                Enable;
    logic [PERIOD_W-1:0] Period;
    logic [2:0]          Os_cfg;
    logic                Os2, Os1, Os0;
    logic                Rd_req;
    logic                Rd_done;
    logic [FRAME_W-1:0]  Rd_data;
    logic                Rd_abort;
    logic [FRAME_W-1:0]  Data_out;
    logic                Data_valid;
    logic                Data_ready;
    logic [CNT_W-1:0]    Sample_cnt;
    logic [CNT_W-1:0]    Miss_cnt;
    logic [CNT_W-1:0]    Drop_cnt;
    logic                Timeout;
    logic [STATE_W-1:0]  State;

    ad7609_sample_sched #(
        .PERIOD_W    (PERIOD_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Enable     (Enable),
        .Period     (Period),
        .Os_cfg     (Os_cfg),
        .Os2        (Os2),
        .Os1        (Os1),
        .Os0        (Os0),
        .Rd_req     (Rd_req),
        .Rd_done    (Rd_done),
        .Rd_data    (Rd_data),
        .Rd_abort   (Rd_abort),
        .Data_out   (Data_out),
        .Data_valid (Data_valid),
        .Data_ready (Data_ready),
        .Sample_cnt (Sample_cnt),
        .Miss_cnt   (Miss_cnt),
        .Drop_cnt   (Drop_cnt),
        .Timeout    (Timeout),
        .State      (State)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Bench bookkeeping
    int cyc          = 0;
    int reader_delay = 300;   // 0 = reader never answers
    int n_req        = 0;
    int n_done       = 0;
    int n_abort      = 0;
    int n_stale      = 0;
    int abort_cyc    = 0;
    int due_cyc      = -1;
    bit due_stale    = 1'b0;
    bit model_valid  = 1'b0;
    int model_sample = 0;
    int exp_miss     = 0;
    logic [2:0]         prev_os = 3'b000;
    int                 req_cyc[$];
    logic [2:0]         os_at_req[$];
    logic [2:0]         os_before_req[$];
    logic [FRAME_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    // Reader model and frame scoreboard, evaluated mid-cycle: observe first, then drive.
    initial begin
        Rd_done = 1'b0;
        Rd_data = '0;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                Rd_done      = 1'b0;
                model_valid  = 1'b0;
                model_sample = 0;
                exp_q.delete();
                due_stale    = 1'b1;
                prev_os      = 3'b000;
            end else begin
                bit cap;
                check("data_valid", Data_valid, model_valid);
                if (Data_valid && Data_ready) begin
                    if (exp_q.size() > 0) check("data_out", Data_out, exp_q.pop_front());
                    else                  check("pending_frames", exp_q.size(), 1);
                end
                if (Rd_req) begin
                    n_req++;
                    req_cyc.push_back(cyc);
                    os_at_req.push_back({Os2, Os1, Os0});
                    os_before_req.push_back(prev_os);
                    if (reader_delay > 0) begin
                        due_cyc   = cyc + reader_delay;
                        due_stale = 1'b0;
                    end
                end
                if (Rd_abort) begin
                    n_abort++;
                    abort_cyc = cyc;
                    due_cyc   = -1;
                end
                prev_os = {Os2, Os1, Os0};
                Rd_done = 1'b0;
                cap     = 1'b0;
                if (due_cyc == cyc) begin
                    Rd_data = {$urandom, $urandom, $urandom, $urandom};
                    Rd_done = 1'b1;
                    due_cyc = -1;
                    if (due_stale) begin
                        n_stale++;
                    end else begin
                        n_done++;
                        cap = !model_valid || Data_ready;
                        if (cap) begin
                            exp_q.push_back(Rd_data);
                            model_sample++;
                        end
                    end
                end
                if (cap)                              model_valid = 1'b1;
                else if (model_valid && Data_ready)   model_valid = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic wait_reqs(input int target, input int budget);
        int k = 0;
        while (n_req < target && k < budget) begin step(1); k++; end
        if (n_req < target) check("wait_rd_req", n_req, target);
    endtask

    task automatic wait_dones(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin step(1); k++; end
        if (n_done < target) check("wait_rd_done", n_done, target);
    endtask

    task automatic wait_aborts(input int target, input int budget);
        int k = 0;
        while (n_abort < target && k < budget) begin step(1); k++; end
        if (n_abort < target) check("wait_rd_abort", n_abort, target);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        step(1);
        while (State != 3'd0 && k < budget) begin step(1); k++; end
        if (State != 3'd0) check("wait_idle", State, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},      State, 0);
        check({tag, "_os"},         {Os2, Os1, Os0}, 0);
        check({tag, "_rd_req"},     Rd_req, 0);
        check({tag, "_rd_abort"},   Rd_abort, 0);
        check({tag, "_data_out"},   Data_out, 0);
        check({tag, "_data_valid"}, Data_valid, 0);
        check({tag, "_timeout"},    Timeout, 0);
        check({tag, "_sample_cnt"}, Sample_cnt, 0);
        check({tag, "_miss_cnt"},   Miss_cnt, 0);
        check({tag, "_drop_cnt"},   Drop_cnt, 0);
    endtask

    initial begin
        int e0, t1, t2, base;
        Rst        = 1'b1;
        Enable     = 1'b0;
        Period     = PERIOD_W'(1000);
        Os_cfg     = 3'b000;
        Data_ready = 1'b1;
        step(3);
        check_reset("reset");
        Rst = 1'b0;
        step(2);
        check_reset("post_reset");

        // Nominal: period 1000, reader answers after 300 cycles
        req_cyc.delete();
        base   = n_done;
        e0     = cyc;
        Enable = 1'b1;
        wait_reqs(n_req + 5, 6000);
        check("t1_first_req", req_cyc[0] - e0, 1002);
        for (int i = 1; i < 5; i++) check("t1_spacing", req_cyc[i] - req_cyc[i-1], 1000);
        wait_dones(base + 5, 1000);
        step(2);
        check("t1_sample_cnt", Sample_cnt, 5);
        check("t1_miss_cnt", Miss_cnt, 0);
        check("t1_drop_cnt", Drop_cnt, 0);
        Enable = 1'b0;
        wait_idle(3000);

        // Period below the minimum is clamped to 200
        Period       = PERIOD_W'(50);
        reader_delay = 100;
        req_cyc.delete();
        e0     = cyc;
        Enable = 1'b1;
        wait_reqs(n_req + 4, 1500);
        check("t2_first_req", req_cyc[0] - e0, 202);
        for (int i = 1; i < 4; i++) check("t2_spacing", req_cyc[i] - req_cyc[i-1], 200);
        Enable = 1'b0;
        wait_idle(500);
        check("t2_sample_cnt", Sample_cnt, model_sample);
        check("t2_miss_cnt", Miss_cnt, 0);

        // Slow reader: every other tick is missed
        Period       = PERIOD_W'(1000);
        reader_delay = 1500;
        req_cyc.delete();
        Enable = 1'b1;
        wait_reqs(n_req + 3, 7000);
        for (int i = 1; i < 3; i++) check("t3_spacing", req_cyc[i] - req_cyc[i-1], 2000);
        exp_miss = 2;
        check("t3_miss_cnt", Miss_cnt, exp_miss);
        Enable = 1'b0;
        wait_idle(2000);
        exp_miss = 3;
        check("t3_miss_after_drain", Miss_cnt, exp_miss);

        // Consumer stalled for three frames: first kept, two dropped
        Data_ready   = 1'b0;
        reader_delay = 300;
        base   = n_done;
        Enable = 1'b1;
        wait_dones(base + 3, 4000);
        step(5);
        check("t4_drop_cnt", Drop_cnt, 2);
        check("t4_valid_held", Data_valid, 1);
        check("t4_held_frames", exp_q.size(), 1);
        check("t4_frame1_held", Data_out, exp_q[0]);
        Data_ready = 1'b1;
        step(1);
        check("t4_valid_cleared", Data_valid, 0);
        Enable = 1'b0;
        wait_idle(1500);

        // Reader never answers: abort after TIMEOUT_CYC, next request on the following tick
        reader_delay = 0;
        base   = n_abort;
        Enable = 1'b1;
        wait_reqs(n_req + 1, 1100);
        t1 = req_cyc[req_cyc.size() - 1];
        wait_aborts(base + 1, 1700);
        check("t5_abort_latency", abort_cyc - t1, TIMEOUT_CYC);
        check("t5_timeout_set", Timeout, 1);
        wait_reqs(n_req + 1, 500);
        t2 = req_cyc[req_cyc.size() - 1];
        check("t5_req_after_abort", t2 - t1, 2000);
        exp_miss = 4;
        check("t5_miss_cnt", Miss_cnt, exp_miss);
        Enable = 1'b0;
        wait_idle(2000);
        exp_miss = 5;
        check("t5_miss_after_drain", Miss_cnt, exp_miss);
        check("t5_abort_pulses", n_abort - base, 2);
        check("t5_timeout_sticky", Timeout, 1);

        // Os pins only follow Os_cfg at a request; then reset mid-frame
        Os_cfg       = 3'b000;
        reader_delay = 300;
        Enable       = 1'b1;
        step(2);
        check("t6_timeout_cleared", Timeout, 0);
        wait_reqs(n_req + 1, 1100);
        step(49);
        Os_cfg = 3'b011;
        step(10);
        check("t6_os_mid_frame", {Os2, Os1, Os0}, 3'b000);
        wait_reqs(n_req + 1, 1000);
        t2 = req_cyc[req_cyc.size() - 1];
        check("t6_os_before_req", os_before_req[os_before_req.size() - 1], 3'b000);
        check("t6_os_at_req", os_at_req[os_at_req.size() - 1], 3'b011);
        step(100);
        Rst    = 1'b1;
        Enable = 1'b0;
        #1;
        check_reset("t6_async_reset");
        step(3);
        Rst = 1'b0;
        while (cyc < t2 + 305) step(1);
        check("t6_late_done_driven", n_stale, 1);
        check_reset("t6_late_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ad7609_sample_sched.md
# ad7609_sample_sched

Sample scheduler for the AD7609 8-channel ADC reader. It issues conversion/read requests to the reader at a programmable period and drives the oversampling pins. It captures each completed 8×16-bit frame into an output register with a valid/ready handshake, and counts missed ticks, dropped frames and reader timeouts. It sits between the system control registers and the ADC reader block.

## Interface
Parameters:
- PERIOD_W, 24, width of the sample-period register, in Clk cycles
- TIMEOUT_CYC, 100000, maximum Clk cycles allowed from request to Rd_done
- CNT_W, 16, width of the statistics counters

Ports:
- Clk  in  1  system clock, 100 MHz
- Rst  in  1  asynchronous, active-high reset
- Enable  in  1  level; 1 = run periodic sampling
- Period  in  PERIOD_W  sample period in Clk cycles; values below 200 are clamped to 200
- Os_cfg  in  3  requested oversampling ratio code
- Os2, Os1, Os0  out  1 each  oversampling pins to the ADC
- Rd_req  out  1  one-cycle pulse that starts one reader frame
- Rd_done  in  1  one-cycle pulse: frame complete, Rd_data valid this cycle
- Rd_data  in  128  {ch1..ch8}, ch1 in [127:112]
- Rd_abort  out  1  one-cycle pulse on timeout; the reader returns to idle
- Data_out  out  128  last captured frame
- Data_valid  out  1  Data_out holds an unconsumed frame
- Data_ready  in  1  consumer accepts when Data_valid && Data_ready
- Sample_cnt  out  CNT_W  frames captured; wraps
- Miss_cnt  out  CNT_W  ticks missed while a frame was still in flight; saturates
- Drop_cnt  out  CNT_W  frames dropped because the output was full; saturates
- Timeout  out  1  sticky; cleared by Rst or by a rising edge on Enable
- State  out  3  current state code, for debug

## Operation
- State encoding: IDLE=0, WAIT_TICK=1, REQ=2, WAIT_DONE=3, DRAIN=4.
- IDLE:
  - When Enable=1, clear the period counter, load Os pins from Os_cfg, and go to WAIT_TICK.
- WAIT_TICK:
  - On tick, go to REQ.
  - If Enable=0, go to IDLE.
- REQ:
  - Assert Rd_req for exactly one cycle, latch Os_cfg onto Os2..Os0, clear the timeout counter, and go to WAIT_DONE.
- WAIT_DONE:
  - On Rd_done, capture the frame (see below).
  - Then go to WAIT_TICK if Enable=1, or to DRAIN if Enable=0.
  - If the timeout counter reaches TIMEOUT_CYC-1 without Rd_done: pulse Rd_abort, set Timeout, and take the same exit as for Rd_done.
- DRAIN:
  - Go to IDLE once Data_valid=0, or immediately if Enable returns to 1 (then go to WAIT_TICK).
- Period counter:
  - Runs whenever the state is not IDLE.
  - The tick is a one-cycle pulse when the count equals eff_period-1, where eff_period = max(Period, 200). The counter then wraps to 0.
  - Period is resampled at each wrap.
- Tick outside WAIT_TICK (in REQ or WAIT_DONE): Miss_cnt increments (saturating). No request is queued.
- Capture on Rd_done:
  - If Data_valid=0, or the consumer accepts in the same cycle: load Data_out, set Data_valid=1, and increment Sample_cnt.
  - Otherwise: keep the old Data_out and increment Drop_cnt (saturating).
- Handshake: Data_valid clears on acceptance unless a capture occurs in the same cycle. Data_out is stable while Data_valid=1 and not accepted.
- Os pins change only in the REQ state, never mid-frame.
- Rd_done while not in WAIT_DONE is ignored; no counters change.

## Timing
- Reset values:
  - state IDLE; all counters 0.
  - Os2..Os0 = 0; Rd_req = 0; Rd_abort = 0.
  - Data_out = 0; Data_valid = 0; Timeout = 0.
- Enable rise → first Rd_req is eff_period+2 cycles later: 1 cycle IDLE→WAIT_TICK, eff_period cycles to the tick, 1 cycle into REQ.
- Steady state: one Rd_req per eff_period cycles when the frame time is less than eff_period-2.
- Rd_done at cycle n → Data_valid=1 and Data_out updated at cycle n+1.
- Timeout: Rd_abort is asserted TIMEOUT_CYC cycles after the Rd_req cycle.
- Rst asserted mid-frame: all outputs return to reset values immediately. A following Rd_done is ignored, because the state is IDLE.

## Structure
- Shared package ad7609_pkg:
  - state localparams and the STATE_W=3 constant
  - CH_NUM=8, CH_W=16, FRAME_W=128
  - PERIOD_MIN=200
- Sub-module ad7609_tick_gen holds the period counter, clamping and tick generation (inputs Clk, Rst, run, Period; output tick).
- The scheduler FSM, capture register and counters stay in the top module.

## Test plan
- Period=1000, Enable held high, reader model returns Rd_done 300 cycles after Rd_req → Rd_req every 1000 cycles, first at cycle 1002; Sample_cnt=5 after 5 frames; Miss_cnt=0.
- Period=50 → clamped: Rd_req spacing is exactly 200 cycles.
- Reader delay 1500 with Period=1000 → Miss_cnt increments once per frame; Rd_req spacing is 2000 cycles.
- Data_ready held 0 for 3 frames → Data_out holds frame 1; Drop_cnt=2; Data_valid=1. Raising Data_ready clears Data_valid the next cycle.
- Reader never answers, TIMEOUT_CYC=100000 → Rd_abort pulse 100000 cycles after Rd_req; Timeout=1. The next Rd_req issues on the following tick.
- Os_cfg changed from 3'b000 to 3'b011 during WAIT_DONE → pins change only at the next Rd_req. Rst pulsed mid-frame → all outputs reset and a late Rd_done is ignored.
